// File: rtl/arp_tx_framer.sv
// arp_tx_framer: builds an Ethernet/ARP reply frame on request and streams it
// byte-wise onto an 8-bit AXIS TX port. The frame is zero-padded to
// MIN_FRAME_BYTES (FCS and preamble are appended downstream), and an
// inter-frame gap of IFG_CYCLES follows every frame.
// Optional build macro ARP_REQUEST_EN adds broadcast ARP request generation
// (ports trig_arp_req / req_ip) with its own one-deep pending slot.
module arp_tx_framer #(
  parameter logic [31:0] LOCAL_IP        = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC       = 48'hABCD_1234_5678,
  parameter int          MIN_FRAME_BYTES = 60,
  parameter int          IFG_CYCLES      = 12
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        trig_arp_tx,
  input  logic [31:0] target_ip,
  input  logic [47:0] target_mac,
`ifdef ARP_REQUEST_EN
  input  logic        trig_arp_req,
  input  logic [31:0] req_ip,
`endif
  output logic [7:0]  arp_tdata,
  output logic        arp_tvalid,
  output logic        arp_tlast,
  output logic        arp_tuser,
  input  logic        arp_tready,
  output logic        arp_busy,
  output logic        arp_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(MIN_FRAME_BYTES - 1);
  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;          // byte index within the frame
  logic [7:0]  gap_q, gap_d;          // cycles spent in the gap
  logic [31:0] tip_q, tip_d;          // TPA of the frame on the wire
  logic [47:0] tmac_q, tmac_d;        // destination / THA of the frame on the wire
  logic        pend_q, pend_d;        // reply waiting behind the current frame
  logic [31:0] pend_ip_q, pend_ip_d;
  logic [47:0] pend_mac_q, pend_mac_d;
  logic        req_q, req_d;          // frame on the wire is a request
  logic        preq_q, preq_d;        // request waiting behind the current frame
  logic [31:0] preq_ip_q, preq_ip_d;

  logic        trig_req_s;
  logic [31:0] req_ip_s;
  logic        trig_any_s;
  logic        hs_s;
  logic        go_s, go_req_s;
  logic [31:0] go_ip_s;
  logic [47:0] go_mac_s;

`ifdef ARP_REQUEST_EN
  assign trig_req_s = trig_arp_req;
  assign req_ip_s   = req_ip;
`else
  assign trig_req_s = 1'b0;
  assign req_ip_s   = 32'h0000_0000;
`endif

  assign trig_any_s = trig_arp_tx | trig_req_s;
  assign hs_s       = (state_q == ST_SEND) & arp_tready;

  // Frame byte at a given index; requests broadcast and carry an all-zero THA.
  function automatic logic [7:0] frame_byte(input logic [7:0] idx, input logic [31:0] ip,
                                            input logic [47:0] mac, input logic is_req);
    logic [47:0] dst;
    logic [7:0]  b;
    dst = is_req ? 48'hFFFF_FFFF_FFFF : mac;
    b   = 8'h00;
    if (idx < 8'd6)       b = dst[8*(5 - int'(idx)) +: 8];
    else if (idx < 8'd12) b = LOCAL_MAC[8*(11 - int'(idx)) +: 8];
    else if (idx < 8'd22) begin
      case (idx)
        8'd12:   b = 8'h08;
        8'd13:   b = 8'h06;
        8'd15:   b = 8'h01;
        8'd16:   b = 8'h08;
        8'd18:   b = 8'h06;
        8'd19:   b = 8'h04;
        8'd21:   b = is_req ? 8'h01 : 8'h02;
        default: b = 8'h00;
      endcase
    end
    else if (idx < 8'd28) b = LOCAL_MAC[8*(27 - int'(idx)) +: 8];
    else if (idx < 8'd32) b = LOCAL_IP[8*(31 - int'(idx)) +: 8];
    else if (idx < 8'd38) b = mac[8*(37 - int'(idx)) +: 8];
    else if (idx < 8'd42) b = ip[8*(41 - int'(idx)) +: 8];
    else                  b = 8'h00;
    return b;
  endfunction

  // Next-state logic: trigger capture, frame launch, byte and gap counting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tip_d      = tip_q;
    tmac_d     = tmac_q;
    req_d      = req_q;
    pend_d     = pend_q;
    pend_ip_d  = pend_ip_q;
    pend_mac_d = pend_mac_q;
    preq_d     = preq_q;
    preq_ip_d  = preq_ip_q;
    go_s       = 1'b0;
    go_req_s   = 1'b0;
    go_ip_s    = 32'h0000_0000;
    go_mac_s   = 48'h0000_0000_0000;

    // Every trigger lands in its pending slot first (newest wins); a launch
    // below clears the slot it consumes.
    if (trig_arp_tx) begin
      pend_d     = 1'b1;
      pend_ip_d  = target_ip;
      pend_mac_d = target_mac;
    end else begin
      pend_d = pend_q;
    end
    if (trig_req_s) begin
      preq_d    = 1'b1;
      preq_ip_d = req_ip_s;
    end else begin
      preq_d = preq_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_arp_tx) begin
          go_s = 1'b1; go_ip_s = target_ip; go_mac_s = target_mac;
        end else if (pend_q) begin
          go_s = 1'b1; go_ip_s = pend_ip_q; go_mac_s = pend_mac_q;
        end else if (trig_req_s) begin
          go_s = 1'b1; go_req_s = 1'b1; go_ip_s = req_ip_s;
        end else if (preq_q) begin
          go_s = 1'b1; go_req_s = 1'b1; go_ip_s = preq_ip_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s && (cnt_q == LAST_IDX)) begin
          cnt_d   = 8'd0;
          gap_d   = 8'd0;
          state_d = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (hs_s) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_GAP: begin
        // A pending frame follows the gap directly; a trigger arriving on the
        // last gap cycle is only captured and launched from IDLE.
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 8'd1;
        end else if (!trig_any_s && pend_q) begin
          go_s = 1'b1; go_ip_s = pend_ip_q; go_mac_s = pend_mac_q;
        end else if (!trig_any_s && preq_q) begin
          go_s = 1'b1; go_req_s = 1'b1; go_ip_s = preq_ip_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_s) begin
      state_d = ST_SEND;
      cnt_d   = 8'd0;
      tip_d   = go_ip_s;
      tmac_d  = go_mac_s;
      req_d   = go_req_s;
      if (go_req_s) preq_d = 1'b0;
      else          pend_d = 1'b0;
    end else begin
      req_d = req_q;
    end
  end

  // State, counters and latched addresses; reset abandons any frame in flight.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      gap_q      <= 8'd0;
      tip_q      <= 32'h0000_0000;
      tmac_q     <= 48'h0000_0000_0000;
      req_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_ip_q  <= 32'h0000_0000;
      pend_mac_q <= 48'h0000_0000_0000;
      preq_q     <= 1'b0;
      preq_ip_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tip_q      <= tip_d;
      tmac_q     <= tmac_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      pend_ip_q  <= pend_ip_d;
      pend_mac_q <= pend_mac_d;
      preq_q     <= preq_d;
      preq_ip_q  <= preq_ip_d;
    end
  end

  // Stream outputs decode registered state only, so tdata holds under backpressure.
  assign arp_tvalid = (state_q == ST_SEND);
  assign arp_tdata  = arp_tvalid ? frame_byte(cnt_q, tip_q, tmac_q, req_q) : 8'h00;
  assign arp_tlast  = arp_tvalid & (cnt_q == LAST_IDX);
  assign arp_tuser  = 1'b0;
  assign arp_done   = arp_tlast & arp_tready;
  assign arp_busy   = (state_q != ST_IDLE) | pend_q | preq_q;

endmodule

// File: tb/tb_arp_tx_framer.sv
// Directed bench for arp_tx_framer: default instance (60 B, IFG 12) and a
// short-frame instance (42 B, IFG 0) share stimulus; sel picks which is observed.
`timescale 1ns/1ps
module tb_arp_tx_framer;

  localparam logic [31:0] LIP  = 32'hC0A8_006E;
  localparam logic [47:0] LMAC = 48'hABCD_1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, trig, tready;
  logic [31:0] tip;
  logic [47:0] tmac;
  logic        treq;
  logic [31:0] rip;
  logic        sel;

  logic [7:0] d0_tdata, d1_tdata;
  logic       d0_tvalid, d0_tlast, d0_tuser, d0_busy, d0_done;
  logic       d1_tvalid, d1_tlast, d1_tuser, d1_busy, d1_done;

  wire [7:0] m_tdata  = sel ? d1_tdata  : d0_tdata;
  wire       m_tvalid = sel ? d1_tvalid : d0_tvalid;
  wire       m_tlast  = sel ? d1_tlast  : d0_tlast;
  wire       m_tuser  = sel ? d1_tuser  : d0_tuser;
  wire       m_busy   = sel ? d1_busy   : d0_busy;
  wire       m_done   = sel ? d1_done   : d0_done;

  arp_tx_framer dut0 (
    .axi_clk(clk), .axi_rstn(rst_n), .trig_arp_tx(trig),
    .target_ip(tip), .target_mac(tmac),
`ifdef ARP_REQUEST_EN
    .trig_arp_req(treq), .req_ip(rip),
`endif
    .arp_tdata(d0_tdata), .arp_tvalid(d0_tvalid), .arp_tlast(d0_tlast),
    .arp_tuser(d0_tuser), .arp_tready(tready), .arp_busy(d0_busy), .arp_done(d0_done)
  );

  arp_tx_framer #(.MIN_FRAME_BYTES(42), .IFG_CYCLES(0)) dut1 (
    .axi_clk(clk), .axi_rstn(rst_n), .trig_arp_tx(trig),
    .target_ip(tip), .target_mac(tmac),
`ifdef ARP_REQUEST_EN
    .trig_arp_req(treq), .req_ip(rip),
`endif
    .arp_tdata(d1_tdata), .arp_tvalid(d1_tvalid), .arp_tlast(d1_tlast),
    .arp_tuser(d1_tuser), .arp_tready(tready), .arp_busy(d1_busy), .arp_done(d1_done)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] rx [0:255];
  int rx_n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: ARP header fields laid end to end, then zero padding.
  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] ip,
                                          input logic [47:0] mac, input bit rq);
    logic [335:0] v;
    v = {(rq ? 48'hFFFF_FFFF_FFFF : mac), LMAC, 16'h0806, 16'h0001, 16'h0800,
         8'h06, 8'h04, (rq ? 16'h0001 : 16'h0002), LMAC, LIP,
         (rq ? 48'h0 : mac), ip};
    if (i < 42) return v[335 - 8*i -: 8];
    return 8'h00;
  endfunction

  task automatic check_frame(input logic [31:0] ip, input logic [47:0] mac, input bit rq);
    int minb = sel ? 42 : 60;
    chk("frame_len", 64'(rx_n), 64'(minb));
    for (int i = 0; i < minb && i < rx_n; i++)
      chk($sformatf("byte%0d", i), 64'(rx[i]), 64'(exp_byte(i, ip, mac, rq)));
  endtask

  // Collect one frame. Entered at a negedge; returns just after the negedge
  // that presents the tlast byte (its handshake is on the following posedge).
  task automatic get_frame(input bit bp, input int ta, input logic [31:0] ipa,
                           input int tb, input logic [31:0] ipb, input int abort_at);
    int   minb = sel ? 42 : 60;
    bit   stall = 1'b0, fin = 1'b0, fa = 1'b0, fb = 1'b0;
    logic [7:0] held = 8'h00;
    rx_n = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      trig   = 1'b0;
      if (m_tvalid && rx_n == ta && !fa) begin trig = 1'b1; tip = ipa; fa = 1'b1; end
      if (m_tvalid && rx_n == tb && !fb) begin trig = 1'b1; tip = ipb; fb = 1'b1; end
      #1;
      if (abort_at >= 0 && rx_n == abort_at && m_tvalid) begin
        rst_n = 1'b0;
        #1;
        chk("rst_drops_tvalid", 64'(m_tvalid), 64'(0));
        fin = 1'b1;
      end else begin
        if (stall && m_tvalid) chk("hold_tdata", 64'(m_tdata), 64'(held));
        if (m_tvalid && tready) begin
          chk("tlast", 64'(m_tlast), 64'(rx_n == minb - 1));
          chk("done",  64'(m_done),  64'(rx_n == minb - 1));
          rx[rx_n] = m_tdata;
          rx_n++;
          if (m_tlast || rx_n > 255) fin = 1'b1;
        end
        stall = m_tvalid && !tready;
        held  = m_tdata;
        if (!fin) @(negedge clk);
      end
    end
    if (!fin) chk("frame_timeout", 64'(0), 64'(1));
  endtask

  task automatic fire(input logic [31:0] ip, input logic [47:0] mac);
    @(negedge clk);
    chk("idle_before_trig", 64'(m_tvalid), 64'(0));
    tip = ip; tmac = mac; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    #1;
    chk("latency_1", 64'(m_tvalid), 64'(1));
  endtask

  task automatic count_gap(output int g);
    g = 0;
    while (!m_tvalid && g < 200) begin
      g++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    tready = 1'b1;
    while (m_busy && c < 500) begin
      c++;
      @(negedge clk);
    end
    chk("busy_clears", 64'(m_busy), 64'(0));
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] hb [0:5];
    int g, extra;
    hb[0] = 8'h00; hb[1] = 8'h11; hb[2] = 8'h22; hb[3] = 8'h33; hb[4] = 8'h44; hb[5] = 8'h55;
    rst_n = 1'b0; trig = 1'b0; tready = 1'b1; tip = 32'h0; tmac = 48'h0;
    treq = 1'b0; rip = 32'h0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    // Reset state of both instances
    chk("rst_tvalid", 64'(d0_tvalid | d1_tvalid), 64'(0));
    chk("rst_tdata",  64'(d0_tdata | d1_tdata),   64'(0));
    chk("rst_tlast",  64'(d0_tlast | d1_tlast),   64'(0));
    chk("rst_tuser",  64'(d0_tuser | d1_tuser),   64'(0));
    chk("rst_busy",   64'(d0_busy | d1_busy),     64'(0));
    chk("rst_done",   64'(d0_done | d1_done),     64'(0));

    // Basic reply, tready held high
    fire(32'hC0A8_0001, 48'h0011_2233_4455);
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_0001, 48'h0011_2233_4455, 1'b0);
    for (int i = 0; i < 6; i++) chk("dst_mac", 64'(rx[i]), 64'(hb[i]));
    chk("ethertype_hi", 64'(rx[12]), 64'(8'h08));
    chk("ethertype_lo", 64'(rx[13]), 64'(8'h06));
    chk("oper_lo",      64'(rx[21]), 64'(8'h02));
    chk("tpa",          64'({rx[38], rx[39], rx[40], rx[41]}), 64'(32'hC0A8_0001));
    chk("pad59",        64'(rx[59]), 64'(8'h00));
    wait_idle();

    // Same reply under random backpressure
    fire(32'hC0A8_0001, 48'h0011_2233_4455);
    get_frame(1'b1, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_0001, 48'h0011_2233_4455, 1'b0);
    wait_idle();

    // Triggers while busy: one-deep queue, last one wins, 12-cycle gap
    fire(32'hC0A8_0001, 48'h0011_2233_4455);
    get_frame(1'b0, 10, 32'hC0A8_0002, 20, 32'hC0A8_0003, -1);
    check_frame(32'hC0A8_0001, 48'h0011_2233_4455, 1'b0);
    @(negedge clk);
    #1;
    count_gap(g);
    chk("ifg_12", 64'(g), 64'(12));
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_0003, 48'h0011_2233_4455, 1'b0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (m_tvalid) extra++;
    end
    chk("no_third_frame", 64'(extra), 64'(0));
    chk("idle_after_two", 64'(m_busy), 64'(0));

    // Reset in the middle of a frame
    fire(32'h0A00_0005, 48'h0200_0000_0001);
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, 30);
    chk("abort_at_30", 64'(rx_n), 64'(30));
    chk("abort_tlast", 64'(m_tlast), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("post_rst_tdata",  64'(m_tdata),  64'(0));
    chk("post_rst_busy",   64'(m_busy),   64'(0));
    chk("post_rst_done",   64'(m_done),   64'(0));
    fire(32'h0A00_0006, 48'h0200_0000_0002);
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'h0A00_0006, 48'h0200_0000_0002, 1'b0);
    wait_idle();

    // Short frame, no IFG: tlast on byte 41, pending frame follows at once
    reset_all();
    sel = 1'b1;
    fire(32'hC0A8_0008, 48'h0A0B_0C0D_0E0F);
    get_frame(1'b0, 20, 32'hC0A8_0009, -1, 32'h0, -1);
    check_frame(32'hC0A8_0008, 48'h0A0B_0C0D_0E0F, 1'b0);
    @(negedge clk);
    #1;
    count_gap(g);
    chk("ifg_0_gap", 64'(g), 64'(1));
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_0009, 48'h0A0B_0C0D_0E0F, 1'b0);
    wait_idle();
    sel = 1'b0;

`ifdef ARP_REQUEST_EN
    // Simultaneous reply and request: reply first, request after the gap
    reset_all();
    @(negedge clk);
    tip = 32'hC0A8_0001; tmac = 48'h0011_2233_4455; trig = 1'b1;
    rip = 32'hC0A8_00FE; treq = 1'b1;
    @(negedge clk);
    trig = 1'b0; treq = 1'b0;
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_0001, 48'h0011_2233_4455, 1'b0);
    @(negedge clk);
    #1;
    count_gap(g);
    chk("req_ifg", 64'(g), 64'(12));
    get_frame(1'b0, -1, 32'h0, -1, 32'h0, -1);
    check_frame(32'hC0A8_00FE, 48'h0, 1'b1);
    chk("req_dst0", 64'(rx[0]),  64'(8'hFF));
    chk("req_oper", 64'(rx[21]), 64'(8'h01));
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
